// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: result-select encodings,
// the in-flight slot record and the write-back mux helper.
package wb_pkg;

  localparam int DEFAULT_ALIGN_DEPTH = 2;
  localparam int RD_W                = 5;
  localparam int XLEN                = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_VDOT = 2'b10,
    WB_SEL_PC4  = 2'b11
  } wb_sel_e;

  // One instruction travelling through the alignment delay line
  typedef struct packed {
    logic            live;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [RD_W-1:0] rd;
    logic            we;
  } slot_t;

  function automatic logic [XLEN-1:0] wb_select(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] vdot,
    input logic [XLEN-1:0] pc
  );
    logic [XLEN-1:0] res;
    case (wb_sel_e'(sel))
      WB_SEL_ALU:  res = alu;
      WB_SEL_MEM:  res = mem;
      WB_SEL_VDOT: res = vdot;
      default:     res = pc + PC_INCR;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-depth shift register that delays instruction control until the
// execute results for that instruction become valid.
module wb_delay_line
  import wb_pkg::*;
#(
  parameter int ALIGN_DEPTH = DEFAULT_ALIGN_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  slot_t                       slot_in,
  output slot_t                       last_slot,
  output logic [RD_W*ALIGN_DEPTH-1:0] rd_taps,
  output logic [ALIGN_DEPTH-1:0]      live_we_taps
);

  slot_t slots [ALIGN_DEPTH];

  // Whole records are cleared on reset so the hazard taps read zero too
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ALIGN_DEPTH; k++) begin
        slots[k] <= '0;
      end
    end else begin
      slots[0] <= slot_in;
      for (int k = 1; k < ALIGN_DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
    end
  end

  assign last_slot = slots[ALIGN_DEPTH-1];

  always_comb begin
    rd_taps      = '0;
    live_we_taps = '0;
    for (int k = 0; k < ALIGN_DEPTH; k++) begin
      rd_taps[RD_W*k +: RD_W] = slots[k].rd;
      live_we_taps[k]         = slots[k].live & slots[k].we;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: aligns EXE control with delayed results, selects the
// register-file write value, and keeps retire/cycle counters.
module wb_stage
  import wb_pkg::*;
#(
  parameter int ALIGN_DEPTH = DEFAULT_ALIGN_DEPTH,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_EXE,
  input  logic                        flush_EXE,
  input  logic [31:0]                 PC_EXE_Hazard,
  input  logic [31:0]                 inst_EXE_Hazard,
  input  logic [4:0]                  rdAddr_EXE_Hazard,
  input  logic                        regWrite_EXE_Hazard,
  input  logic [31:0]                 ALUOut_EXE,
  input  logic [31:0]                 MemDataOut_EXE,
  input  logic [31:0]                 VDOTOut_EXE,
  input  logic [1:0]                  dataToReg_EXE,
  output logic                        valid_WB,
  output logic                        regWrite_WB,
  output logic [4:0]                  rdAddr_WB,
  output logic [31:0]                 wbData_WB,
  output logic [31:0]                 PC_WB,
  output logic [31:0]                 inst_WB,
  output logic [5*ALIGN_DEPTH-1:0]    rdAddr_pipe,
  output logic [ALIGN_DEPTH-1:0]      rdValid_pipe,
  output logic [CNT_W-1:0]            retired_cnt,
  output logic [CNT_W-1:0]            cycle_cnt
);

  if (ALIGN_DEPTH < 1 || ALIGN_DEPTH > 4) begin : g_bad_depth
    $error("wb_stage: ALIGN_DEPTH must be in 1..4");
  end

  slot_t           entry;
  slot_t           last;
  logic [31:0]     wb_mux;

  // Writes to x0 are dropped at entry so neither taps nor commit ever see them
  always_comb begin
    entry      = '0;
    entry.live = valid_EXE & ~flush_EXE;
    entry.pc   = PC_EXE_Hazard;
    entry.inst = inst_EXE_Hazard;
    entry.rd   = rdAddr_EXE_Hazard;
    entry.we   = regWrite_EXE_Hazard & (rdAddr_EXE_Hazard != '0);
  end

  wb_delay_line #(
    .ALIGN_DEPTH (ALIGN_DEPTH)
  ) u_delay (
    .clk          (clk),
    .rst          (rst),
    .slot_in      (entry),
    .last_slot    (last),
    .rd_taps      (rdAddr_pipe),
    .live_we_taps (rdValid_pipe)
  );

  assign wb_mux = wb_select(dataToReg_EXE, ALUOut_EXE, MemDataOut_EXE, VDOTOut_EXE, last.pc);

  // Dead slots still load address/data fields; only valid/write are gated
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_WB    <= 1'b0;
      regWrite_WB <= 1'b0;
      rdAddr_WB   <= '0;
      wbData_WB   <= '0;
      PC_WB       <= '0;
      inst_WB     <= '0;
    end else begin
      valid_WB    <= last.live;
      regWrite_WB <= last.live & last.we;
      rdAddr_WB   <= last.rd;
      wbData_WB   <= wb_mux;
      PC_WB       <= last.pc;
      inst_WB     <= last.inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + CNT_W'(1);
      retired_cnt <= retired_cnt + CNT_W'(valid_WB);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: each driven instruction pushes its expected
// commit record, which is popped and compared when it is due to retire.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int AD = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_EXE, flush_EXE, regWrite_EXE_Hazard;
  logic [31:0]   PC_EXE_Hazard, inst_EXE_Hazard;
  logic [4:0]    rdAddr_EXE_Hazard;
  logic [31:0]   ALUOut_EXE, MemDataOut_EXE, VDOTOut_EXE;
  logic [1:0]    dataToReg_EXE;
  logic          valid_WB, regWrite_WB;
  logic [4:0]    rdAddr_WB;
  logic [31:0]   wbData_WB, PC_WB, inst_WB;
  logic [5*AD-1:0] rdAddr_pipe;
  logic [AD-1:0] rdValid_pipe;
  logic [CW-1:0] retired_cnt, cycle_cnt;

  typedef struct packed {
    logic        v;
    logic        f;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] vdot;
  } instr_t;

  typedef struct {
    int          due;
    logic        live;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] data;
  } exp_t;

  instr_t hist[$];
  exp_t   exp_q[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  wb_stage #(.ALIGN_DEPTH(AD), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_EXE           (valid_EXE),
    .flush_EXE           (flush_EXE),
    .PC_EXE_Hazard       (PC_EXE_Hazard),
    .inst_EXE_Hazard     (inst_EXE_Hazard),
    .rdAddr_EXE_Hazard   (rdAddr_EXE_Hazard),
    .regWrite_EXE_Hazard (regWrite_EXE_Hazard),
    .ALUOut_EXE          (ALUOut_EXE),
    .MemDataOut_EXE      (MemDataOut_EXE),
    .VDOTOut_EXE         (VDOTOut_EXE),
    .dataToReg_EXE       (dataToReg_EXE),
    .valid_WB            (valid_WB),
    .regWrite_WB         (regWrite_WB),
    .rdAddr_WB           (rdAddr_WB),
    .wbData_WB           (wbData_WB),
    .PC_WB               (PC_WB),
    .inst_WB             (inst_WB),
    .rdAddr_pipe         (rdAddr_pipe),
    .rdValid_pipe        (rdValid_pipe),
    .retired_cnt         (retired_cnt),
    .cycle_cnt           (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic instr_t mk(input logic v, input logic f, input logic [31:0] pc,
                                input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [31:0] vdot);
    instr_t x;
    x.v = v; x.f = f; x.pc = pc; x.inst = pc ^ 32'h00A0_0013; x.rd = rd; x.rw = rw;
    x.sel = sel; x.alu = alu; x.mem = mem; x.vdot = vdot;
    return x;
  endfunction

  function automatic instr_t idle();
    return mk(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic logic [31:0] exp_data(input instr_t x);
    case (x.sel)
      2'b00:   return x.alu;
      2'b01:   return x.mem;
      2'b10:   return x.vdot;
      default: return x.pc + 32'd4;
    endcase
  endfunction

  // Drives one EXE cycle: entry fields of x plus the results of the instruction issued AD cycles earlier
  task automatic applyStimulus(input instr_t x);
    instr_t r;
    exp_t   e;
    valid_EXE           = x.v;
    flush_EXE           = x.f;
    PC_EXE_Hazard       = x.pc;
    inst_EXE_Hazard     = x.inst;
    rdAddr_EXE_Hazard   = x.rd;
    regWrite_EXE_Hazard = x.rw;
    hist.push_back(x);
    if (hist.size() > AD) begin
      r = hist.pop_front();
      ALUOut_EXE = r.alu; MemDataOut_EXE = r.mem; VDOTOut_EXE = r.vdot; dataToReg_EXE = r.sel;
    end else begin
      ALUOut_EXE = 32'h0; MemDataOut_EXE = 32'h0; VDOTOut_EXE = 32'h0; dataToReg_EXE = 2'b00;
    end
    e.due  = cyc + AD + 1;
    e.live = x.v & ~x.f;
    e.we   = x.v & ~x.f & x.rw & (x.rd != 5'd0);
    e.rd   = x.rd;
    e.pc   = x.pc;
    e.inst = x.inst;
    e.data = exp_data(x);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_EXE = 1'b0; flush_EXE = 1'b0; regWrite_EXE_Hazard = 1'b0;
    PC_EXE_Hazard = '0; inst_EXE_Hazard = '0; rdAddr_EXE_Hazard = '0;
    ALUOut_EXE = '0; MemDataOut_EXE = '0; VDOTOut_EXE = '0; dataToReg_EXE = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_EXE = 1'b1; flush_EXE = 1'b0; regWrite_EXE_Hazard = 1'b1;
    PC_EXE_Hazard = 32'h40; inst_EXE_Hazard = 32'h1234_5678; rdAddr_EXE_Hazard = 5'd9;
    ALUOut_EXE = 32'hFFFF_FFFF; MemDataOut_EXE = 32'h1; VDOTOut_EXE = 32'h2; dataToReg_EXE = 2'b11;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({valid_WB, regWrite_WB, rdAddr_WB, wbData_WB, PC_WB, inst_WB, rdAddr_pipe, rdValid_pipe,
         retired_cnt, cycle_cnt} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got v=%b we=%b rd=%0d data=%h pc=%h inst=%h taps=%h/%b ret=%0d cyc=%0d, want all zero",
               valid_WB, regWrite_WB, rdAddr_WB, wbData_WB, PC_WB, inst_WB, rdAddr_pipe,
               rdValid_pipe, retired_cnt, cycle_cnt);
    end
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle());
      n_cmp++;
      if ({valid_WB, regWrite_WB} !== 2'b00 || cycle_cnt !== CW'(i + 1)) begin
        n_bad++;
        $display("[TB] FAIL reset_release: got v=%b we=%b cyc=%0d, want v=0 we=0 cyc=%0d",
                 valid_WB, regWrite_WB, cycle_cnt, i + 1);
      end
    end
  endtask

  task automatic test_alu_op();
    exp_t e;
    do_reset();
    applyStimulus(mk(1'b1, 1'b0, 32'h200, 5'd5, 1'b1, WB_SEL_ALU, 32'h0000_1234, 32'hDEAD, 32'hBEEF));
    n_cmp++;
    if (rdValid_pipe !== 2'b01 || rdAddr_pipe[4:0] !== 5'd5) begin
      n_bad++;
      $display("[TB] FAIL alu_tap0: got valid=%b rd=%0d, want valid=01 rd=5", rdValid_pipe, rdAddr_pipe[4:0]);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(idle());
      if (i == 0) begin
        n_cmp++;
        if (rdValid_pipe !== 2'b10 || rdAddr_pipe[9:5] !== 5'd5) begin
          n_bad++;
          $display("[TB] FAIL alu_tap1: got valid=%b rd=%0d, want valid=10 rd=5", rdValid_pipe, rdAddr_pipe[9:5]);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB} !== {e.live, e.we, e.rd, e.pc, e.inst}) begin
          n_bad++;
          $display("[TB] FAIL alu_commit: got v=%b we=%b rd=%0d pc=%h inst=%h, want v=%b we=%b rd=%0d pc=%h inst=%h",
                   valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB, e.live, e.we, e.rd, e.pc, e.inst);
        end
        if (e.live) begin
          n_cmp++;
          if (wbData_WB !== e.data) begin
            n_bad++;
            $display("[TB] FAIL alu_data: got %h, want %h", wbData_WB, e.data);
          end
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (retired_cnt !== CW'(1)) begin
          n_bad++;
          $display("[TB] FAIL alu_retired: got %0d, want 1", retired_cnt);
        end
      end
    end
  endtask

  task automatic test_selects();
    instr_t prog [4];
    exp_t   e;
    do_reset();
    prog[0] = mk(1'b1, 1'b0, 32'h100,  5'd1, 1'b1, WB_SEL_ALU,  32'hA, 32'hB, 32'hC);
    prog[1] = mk(1'b1, 1'b0, 32'h104,  5'd2, 1'b1, WB_SEL_MEM,  32'hA, 32'hB, 32'hC);
    prog[2] = mk(1'b1, 1'b0, 32'h108,  5'd3, 1'b1, WB_SEL_VDOT, 32'hA, 32'hB, 32'hC);
    prog[3] = mk(1'b1, 1'b0, 32'h1000, 5'd4, 1'b1, WB_SEL_PC4,  32'hA, 32'hB, 32'hC);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i < 4 ? prog[i] : idle());
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB} !== {e.live, e.we, e.rd, e.pc, e.inst}) begin
          n_bad++;
          $display("[TB] FAIL sel_commit: got v=%b we=%b rd=%0d pc=%h inst=%h, want v=%b we=%b rd=%0d pc=%h inst=%h",
                   valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB, e.live, e.we, e.rd, e.pc, e.inst);
        end
        if (e.live) begin
          n_cmp++;
          if (wbData_WB !== e.data) begin
            n_bad++;
            $display("[TB] FAIL sel_data: got %h, want %h", wbData_WB, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    instr_t prog [5];
    exp_t   e;
    do_reset();
    prog[0] = mk(1'b1, 1'b0, 32'h300, 5'd6, 1'b1, WB_SEL_ALU, 32'h66, 32'h0, 32'h0);
    prog[1] = mk(1'b1, 1'b1, 32'h304, 5'd7, 1'b1, WB_SEL_ALU, 32'h77, 32'h0, 32'h0);
    prog[2] = mk(1'b1, 1'b0, 32'h308, 5'd8, 1'b1, WB_SEL_MEM, 32'h0, 32'h88, 32'h0);
    prog[3] = mk(1'b0, 1'b1, 32'h30C, 5'd3, 1'b1, WB_SEL_ALU, 32'h33, 32'h0, 32'h0);
    prog[4] = mk(1'b1, 1'b0, 32'h310, 5'd9, 1'b1, WB_SEL_VDOT, 32'h0, 32'h0, 32'h99);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(i < 5 ? prog[i] : idle());
      if (i == 0 || i == 1) begin
        n_cmp++;
        if (rdValid_pipe !== (i == 0 ? 2'b01 : 2'b10)) begin
          n_bad++;
          $display("[TB] FAIL flush_tap: step %0d got %b, want %b", i, rdValid_pipe, (i == 0 ? 2'b01 : 2'b10));
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB} !== {e.live, e.we, e.rd, e.pc, e.inst}) begin
          n_bad++;
          $display("[TB] FAIL flush_commit: got v=%b we=%b rd=%0d pc=%h inst=%h, want v=%b we=%b rd=%0d pc=%h inst=%h",
                   valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB, e.live, e.we, e.rd, e.pc, e.inst);
        end
        if (e.live) begin
          n_cmp++;
          if (wbData_WB !== e.data) begin
            n_bad++;
            $display("[TB] FAIL flush_data: got %h, want %h", wbData_WB, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (retired_cnt !== CW'(3)) begin
      n_bad++;
      $display("[TB] FAIL flush_retired: got %0d, want 3", retired_cnt);
    end
  endtask

  task automatic test_x0();
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       applyStimulus(mk(1'b1, 1'b0, 32'h400, 5'd0, 1'b1, WB_SEL_ALU, 32'h55, 32'h0, 32'h0));
        1:       applyStimulus(mk(1'b1, 1'b0, 32'h404, 5'd3, 1'b0, WB_SEL_ALU, 32'h44, 32'h0, 32'h0));
        default: applyStimulus(idle());
      endcase
      if (i < 2) begin
        n_cmp++;
        if (rdValid_pipe !== 2'b00) begin
          n_bad++;
          $display("[TB] FAIL x0_tap: step %0d got %b, want 00", i, rdValid_pipe);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB} !== {e.live, e.we, e.rd, e.pc, e.inst}) begin
          n_bad++;
          $display("[TB] FAIL x0_commit: got v=%b we=%b rd=%0d pc=%h inst=%h, want v=%b we=%b rd=%0d pc=%h inst=%h",
                   valid_WB, regWrite_WB, rdAddr_WB, PC_WB, inst_WB, e.live, e.we, e.rd, e.pc, e.inst);
        end
        if (e.live) begin
          n_cmp++;
          if (wbData_WB !== e.data) begin
            n_bad++;
            $display("[TB] FAIL x0_data: got %h, want %h", wbData_WB, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1'b1, 1'b0, 32'h500 + 32'(4 * i), 5'(10 + i), 1'b1, WB_SEL_ALU,
                       32'h100 + 32'(i), 32'h0, 32'h0));
      if (i == 1) begin
        n_cmp++;
        if (rdValid_pipe !== 2'b11 || rdAddr_pipe !== {5'd10, 5'd11}) begin
          n_bad++;
          $display("[TB] FAIL mid_taps: got valid=%b rd=%h, want valid=11 rd=%h", rdValid_pipe, rdAddr_pipe, {5'd10, 5'd11});
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({valid_WB, regWrite_WB, rdAddr_WB, wbData_WB} !== {e.live, e.we, e.rd, e.data}) begin
          n_bad++;
          $display("[TB] FAIL mid_commit: got v=%b we=%b rd=%0d data=%h, want v=%b we=%b rd=%0d data=%h",
                   valid_WB, regWrite_WB, rdAddr_WB, wbData_WB, e.live, e.we, e.rd, e.data);
        end
      end
    end
    rst = 1'b1;
    valid_EXE = 1'b1; rdAddr_EXE_Hazard = 5'd13; regWrite_EXE_Hazard = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({valid_WB, regWrite_WB, rdAddr_WB, wbData_WB, PC_WB, inst_WB, rdAddr_pipe, rdValid_pipe,
         retired_cnt, cycle_cnt} !== '0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: got v=%b we=%b rd=%0d taps=%b ret=%0d cyc=%0d, want all zero",
               valid_WB, regWrite_WB, rdAddr_WB, rdValid_pipe, retired_cnt, cycle_cnt);
    end
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(idle());
      n_cmp++;
      if ({valid_WB, regWrite_WB} !== 2'b00 || retired_cnt !== '0) begin
        n_bad++;
        $display("[TB] FAIL mid_after: step %0d got v=%b we=%b ret=%0d, want 0/0/0",
                 i, valid_WB, regWrite_WB, retired_cnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    exp_t e;
    do_reset();
    for (int s = 0; s < 19; s++) begin
      applyStimulus(s < 16 ? mk(1'b1, 1'b0, 32'(s * 4), 5'(s + 1), 1'b1, WB_SEL_ALU, 32'(s), 32'h0, 32'h0)
                           : idle());
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({valid_WB, regWrite_WB, rdAddr_WB, wbData_WB} !== {e.live, e.we, e.rd, e.data}) begin
          n_bad++;
          $display("[TB] FAIL b2b_commit: got v=%b we=%b rd=%0d data=%h, want v=%b we=%b rd=%0d data=%h",
                   valid_WB, regWrite_WB, rdAddr_WB, wbData_WB, e.live, e.we, e.rd, e.data);
        end
      end
      if (s == 16) begin
        n_cmp++;
        if (cycle_cnt !== CW'(1)) begin
          n_bad++;
          $display("[TB] FAIL wrap_cycle: got %0d, want 1", cycle_cnt);
        end
      end
      if (s == 17) begin
        n_cmp++;
        if (retired_cnt !== CW'(15)) begin
          n_bad++;
          $display("[TB] FAIL wrap_retired15: got %0d, want 15", retired_cnt);
        end
      end
      if (s == 18) begin
        n_cmp++;
        if (retired_cnt !== CW'(0) || cycle_cnt !== CW'(3)) begin
          n_bad++;
          $display("[TB] FAIL wrap_retired0: got ret=%0d cyc=%0d, want ret=0 cyc=3", retired_cnt, cycle_cnt);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu_op();
    test_selects();
    test_flush();
    test_x0();
    test_reset_midflight();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
